// File: rtl/encoder_pkg.sv
// Shared types and helpers for the encoder velocity sampler: sampler FSM
// states, the minimum window length and a signed saturation helper.
package encoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } sampler_state_t;

    localparam int MIN_PERIOD = 2;

    typedef struct packed {
        logic        sat;
        logic [63:0] val;
    } sat_result_t;

    // Clamp a sign-extended delta into an out_w-bit signed range; the caller
    // keeps the low out_w bits of val.
    function automatic sat_result_t sat_signed(input logic signed [63:0] d,
                                               input int unsigned        out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_result_t        r;
        hi    = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo    = -hi - 64'sd1;
        r.sat = 1'b0;
        r.val = d;
        if (d > hi) begin
            r.sat = 1'b1;
            r.val = hi;
        end else if (d < lo) begin
            r.sat = 1'b1;
            r.val = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/encoder_velocity_sampler_window_timer.sv
// Loadable down-counter that pulses terminal on the last cycle of each
// measurement window and reloads itself for a back-to-back next window.
module window_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] period,
    input  logic         run,
    output logic         terminal
);

    logic [W-1:0] count;

    assign terminal = run && (count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (start) begin
            count <= period - W'(1);
        end else if (run) begin
            if (count == '0)
                count <= period - W'(1);
            else
                count <= count - W'(1);
        end
    end

endmodule

// File: rtl/encoder_velocity_sampler.sv
// Windowed velocity sampler: snapshots the encoder count every window, emits
// a saturated signed delta over valid/ready, and flags stalls and overruns.
module encoder_velocity_sampler
    import encoder_pkg::*;
#(
    parameter int COUNT_W       = 32,
    parameter int VEL_W         = 16,
    parameter int PERIOD_W      = 24,
    parameter int STALL_WINDOWS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period_cycles,
    input  logic [COUNT_W-1:0]  encoder_count,
    input  logic                state_change,
    output logic [VEL_W-1:0]    vel_data,
    output logic                vel_sat,
    output logic                vel_valid,
    input  logic                vel_ready,
    output logic                overrun,
    input  logic                overrun_clear,
    output logic                stalled
);

    localparam int SC_W = $clog2(STALL_WINDOWS + 1);
    localparam logic [SC_W-1:0] STALL_MAX = SC_W'(STALL_WINDOWS);

    sampler_state_t       state, state_nxt;
    logic                 start, run, terminal;
    logic [PERIOD_W-1:0]  eff_period;
    logic [COUNT_W-1:0]   baseline;
    logic                 activity;
    logic [SC_W-1:0]      stall_cnt, stall_cnt_nxt;
    logic signed [COUNT_W-1:0] delta_s;
    logic signed [63:0]   delta_ext;
    sat_result_t          sat_r;
    logic [VEL_W-1:0]     vel_next;
    logic                 xfer;

    assign eff_period = (period_cycles < PERIOD_W'(MIN_PERIOD)) ?
                        PERIOD_W'(MIN_PERIOD) : period_cycles;

    // Modulo subtraction reinterpreted as signed handles counter wrap.
    assign delta_s   = encoder_count - baseline;
    assign delta_ext = 64'(delta_s);
    assign sat_r     = sat_signed(delta_ext, VEL_W);
    assign vel_next  = VEL_W'(sat_r.val);
    assign xfer      = vel_valid && vel_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        run       = 1'b0;
        case (state)
            IDLE: if (enable) state_nxt = ARM;
            ARM: begin
                start     = 1'b1;
                state_nxt = RUN;
            end
            RUN:     run = 1'b1;
            default: state_nxt = IDLE;
        endcase
        // Disable aborts any window in progress.
        if (!enable) begin
            state_nxt = IDLE;
            start     = 1'b0;
            run       = 1'b0;
        end
    end

    window_timer #(.W(PERIOD_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .period   (eff_period),
        .run      (run),
        .terminal (terminal)
    );

    // A strobe on the terminal cycle itself still counts as activity.
    always_comb begin
        stall_cnt_nxt = stall_cnt;
        if (activity || state_change)
            stall_cnt_nxt = '0;
        else if (stall_cnt != STALL_MAX)
            stall_cnt_nxt = stall_cnt + SC_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (terminal && vel_valid && !vel_ready) begin
            overrun <= 1'b1;
        end else if (overrun_clear) begin
            overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baseline  <= '0;
            activity  <= 1'b0;
            stall_cnt <= '0;
            stalled   <= 1'b0;
            vel_data  <= '0;
            vel_sat   <= 1'b0;
            vel_valid <= 1'b0;
        end else if (!enable) begin
            activity  <= 1'b0;
            stall_cnt <= '0;
            stalled   <= 1'b0;
            vel_valid <= 1'b0;
        end else if (start) begin
            baseline <= encoder_count;
            activity <= 1'b0;
        end else if (terminal) begin
            // Landing wins over a same-cycle transfer: valid stays high.
            baseline  <= encoder_count;
            vel_data  <= vel_next;
            vel_sat   <= sat_r.sat;
            vel_valid <= 1'b1;
            activity  <= 1'b0;
            stall_cnt <= stall_cnt_nxt;
            stalled   <= (stall_cnt_nxt == STALL_MAX);
        end else begin
            if (run && state_change)
                activity <= 1'b1;
            if (xfer)
                vel_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_encoder_velocity_sampler.sv
// Directed and randomized windows checked against a window-level model of
// the sampler's delta, saturation, handshake, overrun and stall rules.
module tb_encoder_velocity_sampler;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [23:0] period_cycles;
    logic [31:0] encoder_count;
    logic        state_change;
    logic [15:0] vel_data;
    logic        vel_sat;
    logic        vel_valid;
    logic        vel_ready;
    logic        overrun;
    logic        overrun_clear;
    logic        stalled;

    int          n_assert = 0;
    int          n_fail   = 0;

    logic [31:0] m_base;
    int          cur_p;
    bit          m_valid;
    bit          m_ovr;
    int          m_idle;
    logic [15:0] m_data;
    bit          m_sat;

    encoder_velocity_sampler #(
        .COUNT_W(32), .VEL_W(16), .PERIOD_W(24), .STALL_WINDOWS(8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .period_cycles (period_cycles),
        .encoder_count (encoder_count),
        .state_change  (state_change),
        .vel_data      (vel_data),
        .vel_sat       (vel_sat),
        .vel_valid     (vel_valid),
        .vel_ready     (vel_ready),
        .overrun       (overrun),
        .overrun_clear (overrun_clear),
        .stalled       (stalled)
    );

    always #5 clk = ~clk;

    function automatic int effp(input int p);
        return (p < 2) ? 2 : p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise enable from IDLE; the count driven during the ARM cycle is the baseline.
    task automatic arm(input int p, input logic [31:0] c);
        period_cycles = 24'(p);
        enable        = 1'b1;
        @(negedge clk);
        encoder_count = c;
        m_base        = c;
        cur_p         = effp(p);
        m_valid       = 1'b0;
        m_idle        = 0;
        @(negedge clk);
    endtask

    // One full window starting at its first RUN cycle.
    // rmode: 0 ready low, 1 ready high, 2 ready only on the terminal cycle.
    // clr_at: cycle index of an overrun_clear pulse (0 = none).
    task automatic window(input logic [31:0] end_cnt, input int nxtp, input int rmode,
                          input bit chg, input int clr_at);
        int          p;
        int          chg_at;
        bit          v0;
        logic [15:0] old;
        logic [31:0] diff;
        int          sd;
        p      = cur_p;
        chg_at = int'($urandom_range(p, 1));
        v0     = m_valid;
        old    = m_data;
        for (int k = 1; k <= p; k++) begin
            if (k == 1) period_cycles = 24'(nxtp);
            encoder_count = (k == p) ? end_cnt : $urandom;
            state_change  = chg && (k == chg_at);
            vel_ready     = (rmode == 1) || (rmode == 2 && k == p);
            overrun_clear = (clr_at != 0) && (k == clr_at);
            if (clr_at != 0 && k == clr_at + 1)
                chk("overrun_cleared", 32'(overrun), 32'd0);
            if (k == p) begin
                if (!v0 || rmode == 1) begin
                    chk("valid_low_before_terminal", 32'(vel_valid), 32'd0);
                end else begin
                    chk("valid_held", 32'(vel_valid), 32'd1);
                    chk("data_stable", 32'(vel_data), 32'(old));
                end
            end
            @(negedge clk);
        end
        state_change  = 1'b0;
        overrun_clear = 1'b0;

        diff = end_cnt - m_base;
        sd   = $signed(diff);
        if (sd > 32767) begin
            m_data = 16'h7FFF;
            m_sat  = 1'b1;
        end else if (sd < -32768) begin
            m_data = 16'h8000;
            m_sat  = 1'b1;
        end else begin
            m_data = 16'(sd);
            m_sat  = 1'b0;
        end
        m_ovr   = ((clr_at != 0) ? 1'b0 : m_ovr) | (v0 && rmode == 0);
        m_idle  = chg ? 0 : ((m_idle < 8) ? m_idle + 1 : 8);
        m_base  = end_cnt;
        m_valid = 1'b1;
        cur_p   = effp(nxtp);

        chk("valid_landing", 32'(vel_valid), 32'd1);
        chk("vel_data", 32'(vel_data), 32'(m_data));
        chk("vel_sat", 32'(vel_sat), 32'(m_sat));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("stalled", 32'(stalled), 32'(m_idle == 8));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"}, 32'(vel_data), 32'd0);
        chk({tag, "_sat"}, 32'(vel_sat), 32'd0);
        chk({tag, "_valid"}, 32'(vel_valid), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
        chk({tag, "_stalled"}, 32'(stalled), 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        enable        = 1'b0;
        period_cycles = 24'd100;
        encoder_count = 32'd0;
        state_change  = 1'b0;
        vel_ready     = 1'b0;
        overrun_clear = 1'b0;
        m_ovr         = 1'b0;
        m_data        = 16'd0;
        m_sat         = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("post_reset");

        // Basic rate and exact back-to-back window length.
        arm(100, 32'h0000_1000);
        window(32'h0000_1000 + 32'd37, 100, 1, 1'b1, 0);
        window(m_base - 32'd12, 100, 1, 1'b1, 0);

        // Reverse motion and counter wrap in both directions.
        window(32'h0000_0002, 10, 1, 1'b1, 0);
        window(32'hFFFF_FFFD, 10, 1, 1'b1, 0);
        window(32'hFFFF_FFFE, 10, 1, 1'b1, 0);
        window(32'h0000_0003, 10, 1, 1'b1, 0);

        // Saturation both ways.
        window(m_base + 32'd40000, 10, 1, 1'b1, 0);
        window(m_base - 32'd40000, 10, 1, 1'b1, 0);

        // Backpressure, clear, landing-cycle transfer, set-beats-clear.
        window(m_base + 32'd10, 10, 0, 1'b1, 0);
        window(m_base + 32'd20, 10, 0, 1'b1, 0);
        window(m_base + 32'd5, 10, 2, 1'b1, 1);
        window(m_base + 32'd7, 10, 0, 1'b1, 10);
        window(m_base + 32'd1, 10, 1, 1'b1, 1);

        // Stall after eight idle windows, recovery after one active window.
        for (int i = 0; i < 8; i++)
            window(m_base + 32'd3, 10, 1, 1'b0, 0);
        window(m_base + 32'd3, 10, 1, 1'b1, 0);

        // Randomized windows, including period values below the minimum.
        for (int i = 0; i < 14; i++)
            window(m_base + $urandom_range(100000) - 32'd50000,
                   int'($urandom_range(20, 0)), int'($urandom_range(2, 0)),
                   1'($urandom_range(1)),
                   ($urandom_range(1) == 1) ? int'($urandom_range(cur_p, 1)) : 0);

        // Build stalled and overrun, then drop enable mid-window.
        for (int i = 0; i < 9; i++)
            window(m_base + 32'd2, 10, 0, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            encoder_count = $urandom;
            @(negedge clk);
        end
        enable = 1'b0;
        @(negedge clk);
        chk("disable_valid", 32'(vel_valid), 32'd0);
        chk("disable_stalled", 32'(stalled), 32'd0);
        chk("disable_overrun_kept", 32'(overrun), 32'(m_ovr));
        repeat (20) @(negedge clk);
        chk("idle_valid", 32'(vel_valid), 32'd0);

        // Re-enable: fresh baseline, first sample period+1 cycles after ARM.
        arm(30, $urandom);
        window(m_base + 32'd300, 100, 1, 1'b1, 0);

        // Asynchronous reset halfway through a window.
        window(m_base + 32'd1234, 100, 0, 1'b1, 0);
        for (int k = 1; k < 50; k++) begin
            vel_ready     = 1'b0;
            encoder_count = $urandom;
            @(negedge clk);
        end
        chk("pre_reset_valid", 32'(vel_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        chk_all_zero("after_async_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/encoder_velocity_sampler.md
Name: encoder_velocity_sampler

Overview:
Periodic sampling controller for the quadrature encoder counter output. It opens fixed-length measurement windows and snapshots the running encoder count at each window end. Each window's count delta becomes a saturated signed velocity sample, delivered over a valid/ready handshake to the BLDC velocity loop. It also flags stalls (no encoder activity for N windows) and sample overruns.

Parameters:
COUNT_W, 32, width of incoming encoder count
VEL_W, 16, width of signed velocity output
PERIOD_W, 24, width of window-length input
STALL_WINDOWS, 8, consecutive idle windows before stalled asserts (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  run sampling while high
period_cycles  input  PERIOD_W  window length in clk cycles (values <2 treated as 2)
encoder_count  input  COUNT_W  running count from encoder counter (same clock domain)
state_change  input  1  encoder transition strobe for this cycle
vel_data  output  VEL_W  signed counts per window
vel_sat  output  1  vel_data was clamped (sideband, qualified by vel_valid)
vel_valid  output  1  sample available
vel_ready  input  1  consumer accepts sample
overrun  output  1  sticky: a sample was overwritten unconsumed
overrun_clear  input  1  clears overrun
stalled  output  1  no activity for STALL_WINDOWS windows

Behaviour:
- Clock/reset: one clock, clk; reset asynchronous, active-high. During and after reset all outputs are 0, FSM in IDLE, timer/baseline/stall counter 0.
- FSM states: IDLE, ARM, RUN.
  - IDLE: timer held. enable=1 -> ARM.
  - ARM (1 cycle): baseline <= encoder_count; timer <= eff_period-1; activity <= 0; -> RUN.
  - RUN: timer decrements each cycle. Terminal cycle = timer==0.
  - enable=0 in any state -> IDLE next cycle, regardless of any window in progress. On that transition: vel_valid, stalled and the stall counter clear; overrun is retained.
- Window length: exactly eff_period cycles, back to back. eff_period = max(period_cycles, 2), sampled only at ARM and at each reload. A change mid-window takes effect at the next window.
- Terminal cycle, registered at its closing edge:
  - delta = encoder_count - baseline, modulo 2^COUNT_W, interpreted as signed (handles count wrap).
  - vel_data <= delta clamped to [-2^(VEL_W-1), 2^(VEL_W-1)-1]; vel_sat <= clamp occurred.
  - baseline <= encoder_count; timer <= eff_period-1; vel_valid <= 1.
- Latency: vel_valid rises the cycle after the terminal cycle. The first sample appears eff_period+1 cycles after ARM.
- Handshake:
  - Transfer occurs on a cycle with vel_valid && vel_ready.
  - vel_data and vel_sat are stable while vel_valid=1 and not transferred.
  - After a transfer, vel_valid drops next cycle unless a new sample lands that same edge; then it stays 1 with new data and overrun is not set.
- Overrun: a new sample lands while vel_valid=1 and vel_ready=0 -> new data replaces old (latest wins), overrun <= 1.
  - overrun clears only on overrun_clear or reset.
  - If set and clear coincide, set wins.
- Activity and stall:
  - activity is set by state_change on any RUN cycle, including the terminal cycle.
  - Window end with no activity: stall counter increments, saturating at STALL_WINDOWS.
  - Window end with activity: counter <= 0.
  - stalled = (counter == STALL_WINDOWS), registered.
  - activity clears at each window end.

Decomposition:
- Shared package encoder_pkg holds:
  - sampler state enum (IDLE, ARM, RUN);
  - MIN_PERIOD = 2 constant;
  - signed saturate function (COUNT_W -> VEL_W).
- Sub-module window_timer: loadable down-counter of width PERIOD_W.
  - Inputs: start, period, run.
  - Output: terminal pulse; reloads itself on terminal.

Test Plan:
- Basic rate: period=100, count +37 in window -> vel_valid at cycle 101 after ARM, vel_data=37, vel_sat=0; the next window is also exactly 100 cycles.
- Reverse and wrap: baseline 0x00000002, count to 0xFFFFFFFD -> vel_data=0xFFFB (-5). Baseline 0xFFFFFFFE, count to 0x00000003 -> vel_data=5.
- Saturation: delta +40000, VEL_W=16 -> vel_data=0x7FFF, vel_sat=1. Delta -40000 -> 0x8000, vel_sat=1.
- Backpressure: vel_ready=0 for two windows (deltas 10 then 20) -> overrun=1, vel_data=20. Ready on the next sample's landing cycle -> no new overrun. overrun_clear -> 0.
- Stall: period=10, no state_change for 8 windows -> stalled=1 the cycle after 8th terminal. One state_change in the 9th window -> stalled=0 after its end.
- Reset/enable mid-window: assert reset at cycle 50 of 100 -> all outputs 0 immediately. Drop enable mid-window -> vel_valid=0 and stalled=0 next cycle, overrun retained; re-enable -> fresh ARM baseline, first sample after period+1 cycles.
